vote_input_conditioner: RTL and testbench

VOTE_INPUT_CONDITIONER -- requirements
Module: vote_input_conditioner

---
 rtl/vote_input_conditioner.sv | 177 +++++++++++++++++
 tb/tb_vote_input_conditioner.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vote_input_conditioner.sv
// Voting console front end: synchronizes and debounces five ballot buttons,
// then arms, accepts, locks and times out one ballot at a time.
module vote_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int ARMED_TIMEOUT   = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       voting_en,
   input  logic       next_voter,
   input  logic [4:0] btn_raw,
   output logic       vote_A,
   output logic       vote_B,
   output logic       vote_C,
   output logic       vote_D,
   output logic       vote_E,
   output logic       ballot_armed,
   output logic       multi_press_err,
   output logic       timeout,
   output logic [7:0] ballot_count
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam int TW = $clog2(ARMED_TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] TMR_LAST = TW'(ARMED_TIMEOUT - 1);

   localparam logic [1:0] IDLE       = 2'd0;
   localparam logic [1:0] WAIT_VOTER = 2'd1;
   localparam logic [1:0] ARMED      = 2'd2;
   localparam logic [1:0] LOCKED     = 2'd3;

   logic [4:0] sync1_reg;
   logic [4:0] sync2_reg;
   logic [4:0] deb_level;
   logic [4:0] press;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
      end else begin
         sync1_reg <= btn_raw;
         sync2_reg <= sync1_reg;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_deb
         logic [CW-1:0] cnt_reg;
         logic          level_reg;
         logic          press_reg;
         logic          mismatch;
         logic          flip;

         assign mismatch = sync2_reg[gi] ^ level_reg;
         assign flip     = mismatch && (cnt_reg == CNT_LAST);

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               cnt_reg   <= '0;
               level_reg <= 1'b0;
               press_reg <= 1'b0;
            end else begin
               if (!mismatch || flip)
                  cnt_reg <= '0;
               else
                  cnt_reg <= cnt_reg + 1'b1;
               if (flip)
                  level_reg <= ~level_reg;
               // Only the rising toggle counts as a press; it lasts one cycle.
               press_reg <= flip & ~level_reg;
            end
         end

         assign deb_level[gi] = level_reg;
         assign press[gi]     = press_reg;
      end
   endgenerate

   logic       single_press;
   logic       multi_press;
   logic       all_released;

   assign single_press = (press != 5'd0) && ((press & (press - 5'd1)) == 5'd0);
   assign multi_press  = (press != 5'd0) && !single_press;
   assign all_released = (deb_level == 5'd0);

   logic [1:0]    state_reg, state_next;
   logic [TW-1:0] tmr_reg, tmr_next;
   logic [4:0]    vote_reg, vote_next;
   logic          err_reg, err_next;
   logic          to_reg, to_next;
   logic          armed_reg;
   logic [7:0]    count_reg, count_next;

   always_comb begin
      state_next = state_reg;
      tmr_next   = tmr_reg;
      vote_next  = 5'd0;
      err_next   = 1'b0;
      to_next    = 1'b0;
      count_next = count_reg;
      case (state_reg)
         IDLE: begin
            if (voting_en)
               state_next = WAIT_VOTER;
         end
         WAIT_VOTER: begin
            if (next_voter && all_released) begin
               state_next = ARMED;
               tmr_next   = '0;
            end
         end
         ARMED: begin
            if (single_press) begin
               vote_next  = press;
               count_next = (count_reg == 8'hFF) ? count_reg : count_reg + 8'd1;
               state_next = LOCKED;
            end else begin
               err_next = multi_press;
               if (tmr_reg == TMR_LAST) begin
                  to_next    = 1'b1;
                  state_next = WAIT_VOTER;
               end else begin
                  tmr_next = tmr_reg + 1'b1;
               end
            end
         end
         LOCKED: begin
            if (all_released)
               state_next = WAIT_VOTER;
         end
         default: state_next = IDLE;
      endcase
      // Losing the tally aborts everything queued for the next cycle.
      if (!voting_en) begin
         state_next = IDLE;
         vote_next  = 5'd0;
         err_next   = 1'b0;
         to_next    = 1'b0;
         count_next = count_reg;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         tmr_reg   <= '0;
         vote_reg  <= 5'd0;
         err_reg   <= 1'b0;
         to_reg    <= 1'b0;
         armed_reg <= 1'b0;
         count_reg <= 8'd0;
      end else begin
         state_reg <= state_next;
         tmr_reg   <= tmr_next;
         vote_reg  <= vote_next;
         err_reg   <= err_next;
         to_reg    <= to_next;
         armed_reg <= (state_next == ARMED);
         count_reg <= count_next;
      end
   end

   assign vote_A          = vote_reg[0];
   assign vote_B          = vote_reg[1];
   assign vote_C          = vote_reg[2];
   assign vote_D          = vote_reg[3];
   assign vote_E          = vote_reg[4];
   assign ballot_armed    = armed_reg;
   assign multi_press_err = err_reg;
   assign timeout         = to_reg;
   assign ballot_count    = count_reg;

endmodule

// File: tb/tb_vote_input_conditioner.sv
// Scenario bench for vote_input_conditioner: a negedge monitor pops expected
// pulse events from a scoreboard queue filled when each stimulus is driven.
module tb_vote_input_conditioner;

   logic       clk = 1'b0;
   logic       reset;
   logic       voting_en;
   logic       next_voter;
   logic [4:0] btn_raw;
   logic       vote_A, vote_B, vote_C, vote_D, vote_E;
   logic       ballot_armed, multi_press_err, timeout;
   logic [7:0] ballot_count;

   vote_input_conditioner #(.DEBOUNCE_CYCLES(4), .ARMED_TIMEOUT(20)) dut (
      .clk(clk), .reset(reset), .voting_en(voting_en), .next_voter(next_voter),
      .btn_raw(btn_raw), .vote_A(vote_A), .vote_B(vote_B), .vote_C(vote_C),
      .vote_D(vote_D), .vote_E(vote_E), .ballot_armed(ballot_armed),
      .multi_press_err(multi_press_err), .timeout(timeout), .ballot_count(ballot_count)
   );

   always #5 clk = ~clk;

   // Event codes: 1..5 = vote A..E, 6 = multi-press error, 7 = timeout.
   typedef struct {
      int         code;
      logic [7:0] cnt;
   } exp_t;

   exp_t       sb_q[$];
   exp_t       mon_exp;
   int         total = 0;
   int         bad = 0;
   int         mon_hits;
   int         mon_code;
   logic [7:0] exp_count;

   task automatic push_exp(input int code);
      exp_t e;
      if (code >= 1 && code <= 5)
         exp_count = (exp_count == 8'd255) ? 8'd255 : exp_count + 8'd1;
      e.code = code;
      e.cnt  = exp_count;
      sb_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (reset === 1'b0) begin
         mon_hits = $countones({timeout, multi_press_err, vote_E, vote_D, vote_C, vote_B, vote_A});
         if (mon_hits != 0) begin
            mon_code = vote_A ? 1 : vote_B ? 2 : vote_C ? 3 : vote_D ? 4 :
                       vote_E ? 5 : multi_press_err ? 6 : 7;
            total++;
            if (mon_hits > 1) begin
               bad++;
               $display("FAIL pulse_onehot: %0d pulses high together, required at most 1", mon_hits);
            end else if (sb_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_pulse: event %0d count %0d, required no event", mon_code, ballot_count);
            end else begin
               mon_exp = sb_q.pop_front();
               if (mon_code != mon_exp.code || ballot_count !== mon_exp.cnt) begin
                  bad++;
                  $display("FAIL scoreboard: event %0d count %0d, required event %0d count %0d",
                           mon_code, ballot_count, mon_exp.code, mon_exp.cnt);
               end else begin
                  $display("event %0d count %0d as expected", mon_code, ballot_count);
               end
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic arm(input string tag);
      bit got;
      got = 1'b0;
      voting_en  = 1'b1;
      next_voter = 1'b1;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (ballot_armed === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      next_voter = 1'b0;
      total++;
      if (!got) begin
         bad++;
         $display("FAIL %s_arm: ballot_armed=%b after 10 cycles, required 1", tag, ballot_armed);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; voting_en = 1'b0; next_voter = 1'b0; btn_raw = 5'd0; exp_count = 8'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({vote_E, vote_D, vote_C, vote_B, vote_A} !== 5'd0) begin
         bad++; $display("FAIL reset_votes: %b, required 00000", {vote_E, vote_D, vote_C, vote_B, vote_A});
      end
      total++;
      if (ballot_armed !== 1'b0) begin bad++; $display("FAIL reset_armed: %b, required 0", ballot_armed); end
      total++;
      if (multi_press_err !== 1'b0) begin bad++; $display("FAIL reset_err: %b, required 0", multi_press_err); end
      total++;
      if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout: %b, required 0", timeout); end
      total++;
      if (ballot_count !== 8'd0) begin bad++; $display("FAIL reset_count: %0d, required 0", ballot_count); end
      reset = 1'b0;
      cyc(3);
      $display("test_reset checked");
   endtask

   task automatic test_single_vote;
      int  n;
      bit  got;
      arm("single");
      @(posedge clk); #1;
      btn_raw[2] = 1'b1;
      push_exp(3);
      got = 1'b0;
      for (n = 1; n <= 15; n++) begin
         @(negedge clk);
         if (vote_C === 1'b1) begin got = 1'b1; break; end
      end
      // 2 sync edges, 3 counting edges, toggle edge, vote edge = 7 edges; 8th falling edge.
      total++;
      if (!got || n != 8) begin
         bad++; $display("FAIL single_latency: vote_C after %0d falling edges (seen=%0d), required 8", n, got);
      end
      @(posedge clk); #1;
      next_voter = 1'b1;
      cyc(1);
      next_voter = 1'b0;
      cyc(1);
      btn_raw[2] = 1'b0;
      @(negedge clk);
      total++;
      if (ballot_armed !== 1'b0) begin bad++; $display("FAIL locked_ignores_next: armed=%b, required 0", ballot_armed); end
      cyc(10);
      total++;
      if (ballot_count !== 8'd1) begin bad++; $display("FAIL single_count: %0d, required 1", ballot_count); end
      arm("single_rearm");
      voting_en = 1'b0;
      cyc(2);
      total++;
      if (sb_q.size() != 0) begin bad++; $display("FAIL single_pending: %0d events outstanding, required 0", sb_q.size()); end
      $display("test_single_vote checked");
   endtask

   task automatic test_glitch;
      arm("glitch");
      @(posedge clk); #1;
      btn_raw[0] = 1'b1;
      cyc(2);
      btn_raw[0] = 1'b0;
      cyc(10);
      @(negedge clk);
      total++;
      if (ballot_armed !== 1'b1) begin bad++; $display("FAIL glitch_armed: %b, required 1", ballot_armed); end
      voting_en = 1'b0;
      cyc(3);
      total++;
      if (sb_q.size() != 0) begin bad++; $display("FAIL glitch_pending: %0d, required 0", sb_q.size()); end
      $display("test_glitch checked");
   endtask

   task automatic test_multi_press;
      arm("multi");
      @(posedge clk); #1;
      btn_raw[1] = 1'b1; btn_raw[3] = 1'b1;
      push_exp(6);
      cyc(5);
      btn_raw[1] = 1'b0; btn_raw[3] = 1'b0;
      cyc(5);
      total++;
      if (ballot_armed !== 1'b1) begin bad++; $display("FAIL multi_stays_armed: %b, required 1", ballot_armed); end
      btn_raw[4] = 1'b1;
      push_exp(5);
      cyc(5);
      btn_raw[4] = 1'b0;
      cyc(10);
      @(negedge clk);
      total++;
      if (ballot_armed !== 1'b0) begin bad++; $display("FAIL multi_after_vote: armed=%b, required 0", ballot_armed); end
      total++;
      if (sb_q.size() != 0) begin bad++; $display("FAIL multi_pending: %0d, required 0", sb_q.size()); end
      $display("test_multi_press checked");
   endtask

   task automatic test_timeout;
      int n;
      bit got;
      arm("timeout");
      push_exp(7);
      got = 1'b0;
      for (n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (timeout === 1'b1) begin got = 1'b1; break; end
      end
      total++;
      if (!got || n != 20) begin bad++; $display("FAIL timeout_cycles: %0d (seen=%0d), required 20", n, got); end
      total++;
      if (ballot_armed !== 1'b0) begin bad++; $display("FAIL timeout_armed: %b, required 0", ballot_armed); end
      @(posedge clk); #1;
      btn_raw[0] = 1'b1;
      cyc(6);
      btn_raw[0] = 1'b0;
      cyc(12);
      total++;
      if (sb_q.size() != 0) begin bad++; $display("FAIL timeout_pending: %0d, required 0", sb_q.size()); end
      $display("test_timeout checked");
   endtask

   task automatic test_held_button;
      int n;
      bit got;
      bit early;
      @(posedge clk); #1;
      btn_raw[0] = 1'b1;
      cyc(8);
      next_voter = 1'b1;
      early = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (ballot_armed === 1'b1) early = 1'b1;
      end
      total++;
      if (early) begin bad++; $display("FAIL held_no_arm: armed while button held, required not armed"); end
      @(posedge clk); #1;
      btn_raw[0] = 1'b0;
      got = 1'b0;
      for (n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (ballot_armed === 1'b1) begin got = 1'b1; break; end
      end
      next_voter = 1'b0;
      total++;
      if (!got || n != 8) begin bad++; $display("FAIL held_release_arm: %0d (seen=%0d), required 8", n, got); end
      cyc(3);
      voting_en = 1'b0;
      cyc(2);
      total++;
      if (sb_q.size() != 0) begin bad++; $display("FAIL held_pending: %0d, required 0", sb_q.size()); end
      $display("test_held_button checked");
   endtask

   task automatic test_saturate;
      for (int i = 0; i < 256; i++) begin
         arm("sat");
         @(posedge clk); #1;
         btn_raw[i % 5] = 1'b1;
         push_exp(i % 5 + 1);
         cyc(8);
         btn_raw = 5'd0;
         cyc(8);
      end
      @(negedge clk);
      total++;
      if (ballot_count !== 8'd255) begin bad++; $display("FAIL sat_count: %0d, required 255", ballot_count); end
      total++;
      if (sb_q.size() != 0) begin bad++; $display("FAIL sat_pending: %0d, required 0", sb_q.size()); end
      $display("test_saturate checked");
   endtask

   task automatic test_disable;
      arm("disable");
      @(posedge clk); #1;
      btn_raw[3] = 1'b1;
      cyc(6);
      voting_en = 1'b0;
      cyc(1);
      total++;
      if (ballot_armed !== 1'b0) begin bad++; $display("FAIL disable_armed: %b, required 0", ballot_armed); end
      cyc(4);
      btn_raw[3] = 1'b0;
      cyc(10);
      total++;
      if (ballot_count !== 8'd255) begin bad++; $display("FAIL disable_count: %0d, required 255", ballot_count); end
      total++;
      if (sb_q.size() != 0) begin bad++; $display("FAIL disable_pending: %0d, required 0", sb_q.size()); end
      $display("test_disable checked");
   endtask

   task automatic test_reset_mid;
      arm("reset_mid");
      @(posedge clk); #1;
      btn_raw[1] = 1'b1;
      cyc(6);
      reset = 1'b1;
      exp_count = 8'd0;
      #1;
      total++;
      if ({ballot_armed, ballot_count} !== 9'd0) begin
         bad++; $display("FAIL reset_mid_clear: armed=%b count=%0d, required 0 0", ballot_armed, ballot_count);
      end
      @(negedge clk);
      total++;
      if ({vote_E, vote_D, vote_C, vote_B, vote_A} !== 5'd0) begin
         bad++; $display("FAIL reset_mid_vote: %b, required 00000", {vote_E, vote_D, vote_C, vote_B, vote_A});
      end
      cyc(2);
      btn_raw = 5'd0;
      cyc(2);
      reset = 1'b0;
      cyc(10);
      total++;
      if (ballot_armed !== 1'b0 || ballot_count !== 8'd0) begin
         bad++; $display("FAIL reset_mid_after: armed=%b count=%0d, required 0 0", ballot_armed, ballot_count);
      end
      total++;
      if (sb_q.size() != 0) begin bad++; $display("FAIL reset_mid_pending: %0d, required 0", sb_q.size()); end
      $display("test_reset_mid checked");
   endtask

   initial begin
      test_reset();
      test_single_vote();
      test_glitch();
      test_multi_press();
      test_timeout();
      test_held_button();
      test_saturate();
      test_disable();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
